hc_adder_pipe: RTL

//  Parametrised, fully pipelined Han-Carlson parallel-prefix adder/subtractor with valid/ready flow control.

---
 rtl/hc_pkg.sv | 26 ++
 rtl/hc_prefix_cell.sv | 14 +
 rtl/hc_adder_pipe.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/hc_pkg.sv
// Shared types and derived-parameter rules for the Han-Carlson adder pipeline.
package hc_pkg;

  localparam int unsigned MinWidth    = 4;
  localparam int unsigned MaxWidth    = 128;
  localparam int unsigned LatOverhead = 3;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic bit is_pow2(int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic int unsigned hc_lvls(int unsigned w);
    return $clog2(w);
  endfunction

  // Stage 0, pair stage and the two carry/sum stages on top of the odd-bit tree.
  function automatic int unsigned hc_lat(int unsigned w);
    return $clog2(w) + LatOverhead;
  endfunction

endpackage

// File: rtl/hc_prefix_cell.sv
// Black prefix cell; a grey cell is the same cell with p_o left unused downstream.
module hc_prefix_cell (
  input  logic gh_i,
  input  logic ph_i,
  input  logic gl_i,
  input  logic pl_i,
  output logic g_o,
  output logic p_o
);

  assign g_o = gh_i | (ph_i & gl_i);
  assign p_o = ph_i & pl_i;

endmodule

// File: rtl/hc_adder_pipe.sv
// Fully pipelined Han-Carlson adder/subtractor with a single global advance enable.
module hc_adder_pipe
  import hc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned LVLS = hc_lvls(WIDTH);
  localparam int unsigned LAT  = hc_lat(WIDTH);
  localparam int unsigned Half = WIDTH / 2;

  if (!is_pow2(WIDTH) || WIDTH < MinWidth || WIDTH > MaxWidth) begin : g_bad_width
    $error("hc_adder_pipe: WIDTH must be a power of two in 4..128");
  end

  logic             adv;
  logic [LAT-1:0]   valid_d, valid_q;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] s0_g_d, s0_g_q, s0_p_d, s0_p_q;
  logic             s0_c0_d, s0_c0_q;
  logic [Half-1:0]  even_g;
  logic [Half-1:0]  cell_g [LVLS];
  logic [Half-1:0]  cell_p [LVLS];
  gp_t  [Half-1:0]  grp_d  [LVLS];
  gp_t  [Half-1:0]  grp_q  [LVLS];
  logic [WIDTH-1:0] dly_p_d  [LVLS];
  logic [WIDTH-1:0] dly_p_q  [LVLS];
  logic [Half-1:0]  dly_ge_d [LVLS];
  logic [Half-1:0]  dly_ge_q [LVLS];
  logic [LVLS-1:0]  dly_c0_d, dly_c0_q;
  logic [WIDTH-1:0] c_d, c_q, cp_d, cp_q;
  logic             cc0_d, cc0_q;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q, ovf_d, ovf_q;
  logic             unused_p;

  assign adv       = ~valid_q[LAT-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[LAT-1];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  always_comb begin
    b_eff     = sub ? ~b : b;
    s0_c0_d   = sub | cin;
    s0_p_d    = a ^ b_eff;
    s0_g_d    = a & b_eff;
    // Carry-in enters the tree as part of bit 0's generate.
    s0_g_d[0] = (a[0] & b_eff[0]) | (s0_p_d[0] & s0_c0_d);
  end

  // Pair stage: bits (2j+1, 2j) collapse into one odd group term.
  for (genvar j = 0; j < Half; j++) begin : g_pair
    hc_prefix_cell u_cell (
      .gh_i(s0_g_q[2*j+1]),
      .ph_i(s0_p_q[2*j+1]),
      .gl_i(s0_g_q[2*j]),
      .pl_i(s0_p_q[2*j]),
      .g_o (cell_g[0][j]),
      .p_o (cell_p[0][j])
    );
  end

  for (genvar l = 1; l < LVLS; l++) begin : g_lvl
    localparam int Span = 1 << (l - 1);
    for (genvar j = 0; j < Half; j++) begin : g_bit
      if (j >= Span) begin : g_cell
        hc_prefix_cell u_cell (
          .gh_i(grp_q[l-1][j].g),
          .ph_i(grp_q[l-1][j].p),
          .gl_i(grp_q[l-1][j-Span].g),
          .pl_i(grp_q[l-1][j-Span].p),
          .g_o (cell_g[l][j]),
          .p_o (cell_p[l][j])
        );
      end else begin : g_pass
        assign cell_g[l][j] = grp_q[l-1][j].g;
        assign cell_p[l][j] = grp_q[l-1][j].p;
      end
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < LVLS; l++) begin
      for (int unsigned j = 0; j < Half; j++) begin
        grp_d[l][j] = '{g: cell_g[l][j], p: cell_p[l][j]};
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < Half; i++) begin
      even_g[i] = s0_g_q[2*i];
    end
    dly_p_d[0]  = s0_p_q;
    dly_ge_d[0] = even_g;
    dly_c0_d[0] = s0_c0_q;
    for (int unsigned k = 1; k < LVLS; k++) begin
      dly_p_d[k]  = dly_p_q[k-1];
      dly_ge_d[k] = dly_ge_q[k-1];
      dly_c0_d[k] = dly_c0_q[k-1];
    end
  end

  // Odd carries come straight from the tree; even ones need one more grey cell.
  always_comb begin
    c_d    = '0;
    c_d[0] = dly_ge_q[LVLS-1][0];
    for (int unsigned i = 0; i < Half; i++) begin
      c_d[2*i+1] = grp_q[LVLS-1][i].g;
    end
    for (int unsigned i = 1; i < Half; i++) begin
      c_d[2*i] = dly_ge_q[LVLS-1][i] | (dly_p_q[LVLS-1][2*i] & grp_q[LVLS-1][i-1].g);
    end
    cp_d  = dly_p_q[LVLS-1];
    cc0_d = dly_c0_q[LVLS-1];
  end

  always_comb begin
    sum_d   = cp_q ^ {c_q[WIDTH-2:0], cc0_q};
    cout_d  = c_q[WIDTH-1];
    ovf_d   = c_q[WIDTH-1] ^ c_q[WIDTH-2];
    valid_d = {valid_q[LAT-2:0], in_valid};
  end

  // Complete-group propagates are never needed once the tree is done.
  always_comb begin
    unused_p = 1'b0;
    for (int unsigned j = 0; j < Half; j++) begin
      unused_p = unused_p ^ grp_q[LVLS-1][j].p;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      s0_g_q   <= '0;
      s0_p_q   <= '0;
      s0_c0_q  <= 1'b0;
      grp_q    <= '{default: '0};
      dly_p_q  <= '{default: '0};
      dly_ge_q <= '{default: '0};
      dly_c0_q <= '0;
      c_q      <= '0;
      cp_q     <= '0;
      cc0_q    <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (adv) begin
      valid_q  <= valid_d;
      s0_g_q   <= s0_g_d;
      s0_p_q   <= s0_p_d;
      s0_c0_q  <= s0_c0_d;
      grp_q    <= grp_d;
      dly_p_q  <= dly_p_d;
      dly_ge_q <= dly_ge_d;
      dly_c0_q <= dly_c0_d;
      c_q      <= c_d;
      cp_q     <= cp_d;
      cc0_q    <= cc0_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
